edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter CHW, 2, channel index width.
REQ-002 Parameter NCH, 4, number of input channels; SHALL equal 2**CHW.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-005 sig_in  input  NCH  asynchronous level inputs, one per channel.
REQ-006 ev_ready  input  1  consumer accepts the presented event.
REQ-007 ovf_clr  input  1  one-cycle pulse clears all overflow flags.
REQ-008 ev_valid  output  1  event presented on ev_chan/ev_type.
REQ-009 ev_chan  output  CHW  channel number of the presented event.
REQ-010 ev_type  output  1  1 = rising edge, 0 = falling edge.
REQ-011 ovf  output  NCH  sticky per-channel overflow flags.

Function
REQ-012 Each channel SHALL pass sig_in through a 2-flop synchronizer (s) and SHALL hold a previous-value register (p).
REQ-013 rise[c] = s[c] & ~p[c]; fall[c] = ~s[c] & p[c]; p[c] <= s[c] every cycle.
REQ-014 Each channel SHALL hold pend_r[c], pend_f[c] and an order bit recording which pending flag was set first.
REQ-015 Detected rise/fall SHALL set pend_r/pend_f on the next edge.
REQ-016 Edge detected while the same-type flag is already set and not granted that cycle: flag stays 1, event dropped, ovf[c] set.
REQ-017 Edge detected in the same cycle its flag is granted: flag stays 1, no overflow.
REQ-018 ovf[c] SHALL stay set until ovf_clr=1; a new overflow in the clear cycle wins (ovf[c] stays 1).
REQ-019 Channel request = pend_r[c] | pend_f[c]; when both set, the older (per order bit) SHALL be granted first.
REQ-020 Round-robin arbitration: search starts at pointer ptr, wraps modulo NCH; after granting channel c, ptr <= (c+1) mod NCH.
REQ-021 Output register SHALL load a grant when ev_valid=0 or (ev_valid & ev_ready); granted pending flag clears on that edge.
REQ-022 Back-to-back: with ready held 1 and requests pending, ev_valid SHALL stay 1 and a new event SHALL be presented every cycle.
REQ-023 While ev_valid=1 and ev_ready=0, ev_chan, ev_type and ptr SHALL hold stable; no grant occurs.
REQ-024 With no requests at a load opportunity, ev_valid SHALL go 0 on the next edge.
REQ-025 Latency, idle block: input change sampled at edge k -> ev_valid=1 after edge k+3.
REQ-026 Event order per channel SHALL match input edge order; no event SHALL be emitted twice.

Reset
REQ-027 rst=0 SHALL asynchronously clear synchronizers, p, pend_r, pend_f, order bits, ovf, ptr (=0), ev_valid, ev_chan, ev_type to 0.
REQ-028 Reset mid-transfer SHALL drop ev_valid immediately and discard all pending events; no event SHALL emerge after release without a new input edge.
REQ-029 sig_in held high through reset release SHALL produce one rise event (p resets to 0) 3 cycles after release.

Verification
REQ-030 Single edge: ready=1, sig_in[2] 0->1 at edge k -> ev_valid=1, ev_chan=2, ev_type=1 after edge k+3, for one cycle.
REQ-031 Round-robin: all four channels rise same cycle, ready=1 -> events in order ch0,ch1,ch2,ch3 on consecutive cycles; next simultaneous burst starts at ch0 again (ptr wraps).
REQ-032 Backpressure: ready=0 for 10 cycles with ev_valid=1, ch1 pulsed 1->0 -> output holds; after ready=1, ch1 rise then ch1 fall emitted in order.
REQ-033 Overflow: ready=0, ch3 toggles 0->1->0->1 with 4-cycle spacing -> ovf[3]=1; ovf_clr pulse -> ovf=0.
REQ-034 Reset mid-operation: rst=0 while ev_valid=1 and pending events on ch0/ch2 -> ev_valid=0 immediately; after release with inputs static low, ev_valid stays 0.
REQ-035 Same-cycle grant and new edge: ch0 pend_r granted in the cycle a new rise is detected -> second rise event emitted, ovf[0]=0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronized edge detection on NCH inputs,
// per-channel pending rise/fall flags, round-robin event output.
module edge_event_arbiter #(
  parameter int CHW = 2,
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sig_in,
  input  logic           ev_ready,
  input  logic           ovf_clr,
  output logic           ev_valid,
  output logic [CHW-1:0] ev_chan,
  output logic           ev_type,
  output logic [NCH-1:0] ovf
);

  logic [NCH-1:0] meta;
  logic [NCH-1:0] s;
  logic [NCH-1:0] p;
  logic [NCH-1:0] pend_r;
  logic [NCH-1:0] pend_f;
  logic [NCH-1:0] ord;
  logic [CHW-1:0] ptr;

  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] req;
  logic           load;
  logic           gnt_any;
  logic [CHW-1:0] gnt_idx;
  logic [CHW-1:0] cand;
  logic           gnt_type;
  logic           take;
  logic [NCH-1:0] onehot;
  logic [NCH-1:0] gr_r;
  logic [NCH-1:0] gr_f;
  logic [NCH-1:0] r_old;
  logic [NCH-1:0] f_old;
  logic [NCH-1:0] ovf_set;

  assign rise = s & ~p;
  assign fall = ~s & p;
  assign req  = pend_r | pend_f;
  assign load = ~ev_valid | ev_ready;

  // Round-robin search starting at ptr; index wraps since NCH == 2**CHW
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int i = 0; i < NCH; i++) begin
      cand = ptr + CHW'(i);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // ord=1 means the pending rise is older than the pending fall
  assign gnt_type = (pend_r[gnt_idx] & pend_f[gnt_idx])
                  ? ord[gnt_idx] : pend_r[gnt_idx];
  assign take    = load & gnt_any;
  assign onehot  = NCH'(1) << gnt_idx;
  assign gr_r    = (take && gnt_type)  ? onehot : '0;
  assign gr_f    = (take && !gnt_type) ? onehot : '0;

  // Flags that survive this edge; a new edge on a surviving flag is lost
  assign r_old   = pend_r & ~gr_r;
  assign f_old   = pend_f & ~gr_f;
  assign ovf_set = (rise & r_old) | (fall & f_old);

  // Input synchronizers, edge history, pending flags and overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= '0;
      s      <= '0;
      p      <= '0;
      pend_r <= '0;
      pend_f <= '0;
      ord    <= '0;
      ovf    <= '0;
    end else begin
      meta   <= sig_in;
      s      <= meta;
      p      <= s;
      pend_r <= r_old | rise;
      pend_f <= f_old | fall;
      ord    <= (r_old & f_old & ord) | (r_old & ~f_old);
      ovf    <= (ovf & ~{NCH{ovf_clr}}) | ovf_set;
    end
  end

  // Output register loads on an empty slot or an accepted event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_valid <= 1'b0;
      ev_chan  <= '0;
      ev_type  <= 1'b0;
      ptr      <= '0;
    end else if (load) begin
      ev_valid <= gnt_any;
      if (gnt_any) begin
        ev_chan <= gnt_idx;
        ev_type <= gnt_type;
        ptr     <= gnt_idx + CHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed + random stimulus against a
// per-channel event-queue scoreboard for edge_event_arbiter.
module tb_edge_event_arbiter;
  localparam int CHW = 2;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] sig_in = '0;
  logic           ev_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           ev_valid;
  logic [CHW-1:0] ev_chan;
  logic           ev_type;
  logic [NCH-1:0] ovf;

  int checks = 0;
  int errors = 0;

  bit             exp_q[NCH][$];
  logic [NCH-1:0] sig = '0;
  bit             hold_v = 1'b0;
  logic [CHW-1:0] hold_c;
  logic           hold_t;
  bit             mon_t;
  int             age[NCH];
  int             vis;

  always #5 clk = ~clk;

  edge_event_arbiter #(.CHW(CHW), .NCH(NCH)) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .ev_ready(ev_ready),
    .ovf_clr(ovf_clr),
    .ev_valid(ev_valid),
    .ev_chan(ev_chan),
    .ev_type(ev_type),
    .ovf(ovf)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Change one input; an edge that must be reported is queued as expected
  task automatic drive(int c, bit v, bit track);
    sig[c] = v;
    sig_in = sig;
    if (track) exp_q[c].push_back(v);
  endtask

  function automatic int pending_total();
    int n = 0;
    for (int c = 0; c < NCH; c++) n += exp_q[c].size();
    return n;
  endfunction

  task automatic flush();
    for (int c = 0; c < NCH; c++) exp_q[c].delete();
  endtask

  task automatic drain(string name, int budget);
    ev_ready = 1'b1;
    for (int i = 0; i < budget && pending_total() != 0; i++) step(1);
    step(2);
    chk(name, pending_total(), 0);
    chk({name, "_valid"}, ev_valid, 0);
  endtask

  // Monitor: pop per-channel expectations on each accepted event and
  // verify a stalled event stays put
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!(ev_valid === 1'b1 && ev_chan === hold_c &&
              ev_type === hold_t)) begin
          errors++;
          $display("FAIL stall_hold: got v%0b c%0d t%0b expected v1 c%0d t%0b",
                   ev_valid, ev_chan, ev_type, hold_c, hold_t);
        end
      end
      if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
        checks++;
        if (exp_q[ev_chan].size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got c%0d t%0b expected none",
                   ev_chan, ev_type);
        end else begin
          mon_t = exp_q[ev_chan].pop_front();
          if (ev_type !== mon_t) begin
            errors++;
            $display("FAIL event_type ch%0d: got %0b expected %0b",
                     ev_chan, ev_type, mon_t);
          end
        end
      end
      hold_v = (ev_valid === 1'b1) && (ev_ready === 1'b0);
      hold_c = ev_chan;
      hold_t = ev_type;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    rst = 1'b0;
    step(2);
    chk("rst_valid", ev_valid, 0);
    chk("rst_chan", ev_chan, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    ev_ready = 1'b1;
    step(2);

    // Simultaneous rises, then falls: ch0..ch3 back-to-back each time
    for (int v = 1; v >= 0; v--) begin
      for (int c = 0; c < NCH; c++) drive(c, v[0], 1'b1);
      step(3);
      chk("rr_latency", ev_valid, 0);
      for (int c = 0; c < NCH; c++) begin
        step(1);
        chk("rr_valid", ev_valid, 1);
        chk("rr_chan", ev_chan, c);
        chk("rr_type", ev_type, v);
      end
      step(1);
      chk("rr_idle", ev_valid, 0);
    end

    // Single edge latency and one-cycle presentation
    drive(2, 1'b1, 1'b1);
    step(3);
    chk("single_early", ev_valid, 0);
    step(1);
    chk("single_valid", ev_valid, 1);
    chk("single_chan", ev_chan, 2);
    chk("single_type", ev_type, 1);
    step(1);
    chk("single_once", ev_valid, 0);

    // Backpressure with a ch1 pulse queued behind a held event
    ev_ready = 1'b0;
    drive(0, 1'b1, 1'b1);
    step(4);
    chk("bp_valid", ev_valid, 1);
    drive(1, 1'b1, 1'b1);
    step(4);
    drive(1, 1'b0, 1'b1);
    step(10);
    chk("bp_hold_valid", ev_valid, 1);
    chk("bp_hold_chan", ev_chan, 0);
    chk("bp_hold_type", ev_type, 1);
    drain("bp_drain", 20);
    chk("bp_ovf", ovf, 0);

    // Overflow: second ch3 rise lands on a still-pending rise
    ev_ready = 1'b0;
    drive(0, 1'b0, 1'b1);
    step(4);
    chk("ovf_pre_valid", ev_valid, 1);
    drive(3, 1'b1, 1'b1);
    step(4);
    drive(3, 1'b0, 1'b1);
    step(4);
    drive(3, 1'b1, 1'b0);
    step(5);
    chk("ovf_set", ovf, 4'b1000);
    step(3);
    chk("ovf_sticky", ovf, 4'b1000);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    step(1);
    chk("ovf_stay_clr", ovf, 0);
    drain("ovf_drain", 20);

    // ch0 rise granted in the same cycle a new ch0 rise is detected
    ev_ready = 1'b0;
    drive(1, 1'b1, 1'b1);
    step(4);
    chk("same_hold_chan", ev_chan, 1);
    drive(0, 1'b1, 1'b1);
    step(4);
    drive(0, 1'b0, 1'b1);
    step(4);
    drive(0, 1'b1, 1'b1);
    step(2);
    ev_ready = 1'b1;
    step(1);
    drain("same_drain", 20);
    chk("same_ovf", ovf, 0);

    // Reset mid-transfer with ch0/ch2 events outstanding
    ev_ready = 1'b0;
    drive(0, 1'b0, 1'b1);
    drive(2, 1'b0, 1'b1);
    step(6);
    chk("rstmid_pre_valid", ev_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_async_valid", ev_valid, 0);
    flush();
    sig = '0;
    sig_in = sig;
    ev_ready = 1'b1;
    step(2);
    rst = 1'b1;
    vis = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (ev_valid !== 1'b0) vis++;
    end
    chk("rstmid_quiet", vis, 0);
    chk("rstmid_ovf", ovf, 0);

    // Input held high through reset release yields exactly one rise
    rst = 1'b0;
    drive(1, 1'b1, 1'b0);
    step(2);
    exp_q[1].push_back(1'b1);
    rst = 1'b1;
    drain("rst_high_rise", 12);
    step(5);

    // Random traffic, at most two opposite-type events per channel
    for (int c = 0; c < NCH; c++) age[c] = 100;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ev_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NCH; c++) begin
        age[c]++;
        if (exp_q[c].size() <= 1 && age[c] >= 3 &&
            $urandom_range(0, 5) == 0) begin
          drive(c, !sig[c], 1'b1);
          age[c] = 0;
        end
      end
      step(1);
    end
    drain("rand_drain", 60);
    chk("rand_ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
